dm_responder: RTL and testbench
===============================

// Module: dm_responder
// PURPOSE
//   Handshaked data-memory responder: the target side of the CPU load/store port.
//   Accepts one word read or write request at a time and completes it after a
//   programmable number of wait states. It acknowledges with a one-cycle ack pulse.
//   It sits behind the datapath's MemAddr/MemWriteData/MemRead/MemWrite port and
//   models a multi-cycle memory for the stall-capable CPU.
// PARAMETERS
//   DEPTH    256  number of 32-bit words stored (power of two, >=4)
//   LATENCY  2    wait-state cycles between request capture and array access (0..15)
// PORTS
//   clk           in   1   system clock, rising edge
//   rst           in   1   asynchronous, active-high reset
//   req           in   1   request valid; held high by requester until ack seen
//   MemRead       in   1   request is a word read (qualified by req)
//   MemWrite      in   1   request is a word write (qualified by req)
//   MemAddr       in   32  byte address; bits [1:0] ignored
//   MemWriteData  in   32  write data
//   MemReadData   out  32  read data; valid in ack cycle of a read, held until next read ack
//   ack           out  1   one-cycle completion pulse
//   err           out  1   valid with ack: request was out-of-range or illegal
//   busy          out  1   high while a request is in flight (WAIT or RESP)
// BEHAVIOUR
//   Reset (async, immediate): state IDLE, wait counter 0, ack=0, err=0, busy=0.
//     MemReadData=0 and all DEPTH words cleared to 0.
//   Reset mid-request aborts it: an uncommitted write is discarded and no ack is issued.
//   FSM states: IDLE, WAIT, RESP.
//   IDLE, req=1, MemRead XOR MemWrite:
//     Capture op, MemAddr and MemWriteData in internal registers.
//     Load counter with LATENCY; go to WAIT, or to RESP when LATENCY=0.
//   IDLE, req=1, MemRead=MemWrite=1: illegal. Go to RESP with err flagged; no array access.
//   IDLE, req=1, MemRead=MemWrite=0: ignored, stay IDLE.
//   IDLE, req=0: stay IDLE.
//   WAIT: counter decrements each edge; the edge where counter==1 goes to RESP.
//     Inputs are ignored in WAIT; the captured values are used.
//   Array access happens on the edge that enters RESP:
//     write: mem[idx] <= captured data;
//     read:  MemReadData <= mem[idx].
//   idx = captured MemAddr[log2(DEPTH)+1:2].
//   Out of range (any captured MemAddr bit above log2(DEPTH)+1 set):
//     the write is dropped; a read loads MemReadData with 0; err=1 in RESP.
//   RESP: ack=1, err as flagged, busy=1, for exactly one cycle; then unconditionally IDLE.
//     req still high in the RESP cycle is not a new request.
//   req high again in the following IDLE cycle is a new request.
//   Latency: request sampled at edge N in IDLE -> ack high during cycle N+LATENCY+1.
//     Back-to-back requests: one completes every LATENCY+2 cycles.
//   ack/err/busy are registered outputs (no combinational path from inputs).
//   err=0 whenever ack=0.
//   MemReadData is not altered by writes or error-free idle cycles.
//   Counter width is 4 bits. LATENCY=0 never enters WAIT.
// TESTING
//   1 Reset, LATENCY=2: write 0xDEADBEEF @0x10, then read @0x10.
//     -> ack 3 cycles after each sample edge; MemReadData=0xDEADBEEF; err=0.
//   2 Read @0x13 after scenario 1.
//     -> Low bits ignored; MemReadData=0xDEADBEEF.
//   3 Write @0x400 (DEPTH=256) then read @0x0.
//     -> Write ack with err=1; word 0 still 0; read @0x400 returns 0 with err=1.
//   4 req with MemRead=MemWrite=1.
//     -> ack+err one cycle after sample, memory unchanged.
//   4 req with MemRead=MemWrite=0.
//     -> No ack, busy stays 0.
//   5 Change MemAddr/MemWriteData during WAIT.
//     -> Captured values used.
//   5 Hold req high through RESP, drop it next cycle.
//     -> Exactly one ack.
//   6 Assert rst during WAIT of a write 0x1234 @0x8.
//     -> Immediate IDLE, ack never pulses, later read @0x8 returns 0.
//   6 LATENCY=0 build.
//     -> ack in cycle after sample.

Source files
------------

// File: rtl/dm_responder.sv
// Handshaked data-memory responder: accepts one word read or write at a time and
// completes it with a one-cycle ack after LATENCY wait states.
module dm_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] MemAddr,
    input  logic [31:0] MemWriteData,
    output logic [31:0] MemReadData,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic           cap_write;
    logic           cap_oor;
    logic [AW-1:0]  cap_idx;
    logic [31:0]    cap_data;
    logic [31:0]    mem [DEPTH];

    logic           in_legal;
    logic           in_illegal;
    logic           in_oor;
    logic [AW-1:0]  in_idx;
    logic           sel_write;
    logic           sel_oor;
    logic [AW-1:0]  sel_idx;
    logic [31:0]    sel_data;
    logic           do_access;
    logic           unused_addr_bits;

    assign in_legal         = req & (MemRead ^ MemWrite);
    assign in_illegal       = req & MemRead & MemWrite;
    assign in_idx           = MemAddr[AW+1:2];
    assign in_oor           = |MemAddr[31:AW+2];
    assign unused_addr_bits = ^MemAddr[1:0];

    // The array is touched on the edge that enters RESP; with zero latency that is
    // the capture edge itself, so the live inputs stand in for the captured copy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sel_write = cap_write;
        sel_oor   = cap_oor;
        sel_idx   = cap_idx;
        sel_data  = cap_data;
        do_access = 1'b0;
        if (state == IDLE) begin
            sel_write = MemWrite;
            sel_oor   = in_oor;
            sel_idx   = in_idx;
            sel_data  = MemWriteData;
            do_access = in_legal && (LATENCY == 0);
        end else if (state == WAIT) begin
            do_access = (cnt == 4'd1);
        end
    end

    // NOTE: the storage is a flop array, so it is cleared by reset like any other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_access && sel_write && !sel_oor) begin
            mem[sel_idx] <= sel_data;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ack         <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
            cap_write   <= 1'b0;
            cap_oor     <= 1'b0;
            cap_idx     <= '0;
            cap_data    <= '0;
            MemReadData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack  <= 1'b0;
                    err  <= 1'b0;
                    busy <= 1'b0;
                    if (in_illegal) begin
                        state <= RESP;
                        ack   <= 1'b1;
                        err   <= 1'b1;
                        busy  <= 1'b1;
                    end else if (in_legal) begin
                        cap_write <= MemWrite;
                        cap_oor   <= in_oor;
                        cap_idx   <= in_idx;
                        cap_data  <= MemWriteData;
                        cnt       <= 4'(LATENCY);
                        busy      <= 1'b1;
                        if (LATENCY == 0) begin
                            state <= RESP;
                            ack   <= 1'b1;
                            err   <= in_oor;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        ack   <= 1'b1;
                        err   <= cap_oor;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase

            // Out-of-range reads return zero; writes and illegal requests leave it alone.
            if (do_access && !sel_write) begin
                MemReadData <= sel_oor ? '0 : mem[sel_idx];
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: LATENCY=2 and LATENCY=0 instances side by side,
// directed requests push hand-computed expectations, per-instance monitors compare on ack.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ack   [2];
    logic        err   [2];
    logic        busy  [2];

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req(req[0]), .MemRead(rd[0]), .MemWrite(wr[0]),
        .MemAddr(addr[0]), .MemWriteData(wdata[0]), .MemReadData(rdata[0]),
        .ack(ack[0]), .err(err[0]), .busy(busy[0])
    );

    dm_responder #(.DEPTH(256), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req(req[1]), .MemRead(rd[1]), .MemWrite(wr[1]),
        .MemAddr(addr[1]), .MemWriteData(wdata[1]), .MemReadData(rdata[1]),
        .ack(ack[1]), .err(err[1]), .busy(busy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int d);
        exp_t e;
        int   sz;
        if (ack[d]) begin
            sz = (d == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
                check($sformatf("unexpected_ack_d%0d", d), 32'd1, 32'd0);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("err_d%0d", d), 32'(err[d]), 32'(e.err));
                check($sformatf("rdata_d%0d", d), rdata[d], e.data);
                check($sformatf("ack_cycle_d%0d", d), 32'(cyc), 32'(e.cyc));
                check($sformatf("busy_in_resp_d%0d", d), 32'(busy[d]), 32'd1);
            end
        end else if (err[d]) begin
            check($sformatf("err_without_ack_d%0d", d), 32'(err[d]), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Issue one request on instance d and wait (bounded) for its ack.
    task automatic do_req(input int d, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] dt,
                          input logic eerr, input logic [31:0] edata,
                          input bit disturb = 0, input bit hold = 0);
        exp_t e;
        int   lat;
        bit   got;
        lat = (r && w) ? 0 : ((d == 0) ? 2 : 0);
        @(negedge clk);
        req[d] = 1'b1; rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = dt;
        e.data = edata;
        e.err  = eerr;
        e.cyc  = cyc + 1 + lat;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (disturb && i == 0) begin
                addr[d]  = a + 32'h4;
                wdata[d] = 32'h1111_1111;
            end
            if (ack[d]) begin
                got = 1;
                break;
            end
        end
        if (!got) check($sformatf("ack_timeout_d%0d", d), 32'd0, 32'd1);
        if (hold) @(negedge clk);
        req[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        rst = 1'b1;
        #12;
        for (int i = 0; i < 2; i++) begin
            check("reset_rdata", rdata[i], 32'd0);
            check("reset_ack", 32'(ack[i]), 32'd0);
            check("reset_err", 32'(err[i]), 32'd0);
            check("reset_busy", 32'(busy[i]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Basic write/read, low address bits ignored.
        do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 32'hDEAD_BEEF);
        do_req(0, 1'b1, 1'b0, 32'h13, 32'h0,         1'b0, 32'hDEAD_BEEF);

        // Out of range: write dropped, read returns zero with err.
        do_req(0, 1'b0, 1'b1, 32'h400, 32'hAAAA_5555, 1'b1, 32'hDEAD_BEEF);
        do_req(0, 1'b1, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0);
        do_req(0, 1'b1, 1'b0, 32'h400, 32'h0,         1'b1, 32'h0);

        // Illegal request: immediate ack+err, read data held, memory untouched.
        do_req(0, 1'b1, 1'b1, 32'h10, 32'h1234_5678, 1'b1, 32'h0);
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 32'hDEAD_BEEF);

        // No-op request is ignored.
        @(negedge clk);
        req[0] = 1'b1; rd[0] = 1'b0; wr[0] = 1'b0; addr[0] = 32'h10;
        repeat (4) begin
            @(negedge clk);
            check("noop_busy", 32'(busy[0]), 32'd0);
        end
        req[0] = 1'b0;

        // Inputs changed during WAIT are ignored; req held through RESP gives one ack.
        do_req(0, 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF, 1, 0);
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0,         1'b0, 32'hCAFE_F00D, 0, 1);
        do_req(0, 1'b1, 1'b0, 32'h24, 32'h0,         1'b0, 32'h0);

        // Reset during WAIT aborts the write.
        @(negedge clk);
        req[0] = 1'b1; rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'h1234;
        @(negedge clk);
        check("wait_busy", 32'(busy[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_ack", 32'(ack[0]), 32'd0);
        req[0] = 1'b0; wr[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        do_req(0, 1'b1, 1'b0, 32'h8,  32'h0, 1'b0, 32'h0);
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);

        // Zero-latency instance.
        do_req(1, 1'b0, 1'b1, 32'h4,   32'h5A5A_5A5A, 1'b0, 32'h0);
        do_req(1, 1'b1, 1'b0, 32'h4,   32'h0,         1'b0, 32'h5A5A_5A5A);
        do_req(1, 1'b1, 1'b0, 32'h800, 32'h0,         1'b1, 32'h0);
        do_req(1, 1'b1, 1'b1, 32'h4,   32'h0,         1'b1, 32'h0);
        do_req(1, 1'b1, 1'b0, 32'h7,   32'h0,         1'b0, 32'h5A5A_5A5A, 0, 1);

        repeat (10) @(negedge clk);
        check("pending_acks", 32'(q0.size() + q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
